// File: rtl/jpegls_byte_packer_pkg.sv
// rtl/jpegls_byte_packer_pkg.sv - shared defaults, state encoding and stuffing helpers for the JPEG-LS byte packer
package jpegls_byte_packer_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int LEN_W_DEF  = 7;
  localparam int ACC_W_DEF  = 128;

  localparam logic [7:0] MARKER_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FF_PAD = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // A byte following 0xFF carries only 7 payload bits; its MSB is the stuffed zero.
  function automatic logic [3:0] need_bits(input logic last_ff);
    return last_ff ? 4'd7 : 4'd8;
  endfunction

  function automatic logic [7:0] stuff_byte(input logic last_ff, input logic [7:0] top);
    return last_ff ? {1'b0, top[7:1]} : top;
  endfunction

endpackage

// File: rtl/jpegls_bit_accumulator.sv
// rtl/jpegls_bit_accumulator.sv - MSB-aligned bit accumulator with same-cycle consume and append
module jpegls_bit_accumulator #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 7,
  parameter int ACC_W  = 128,
  parameter int FILL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              append_i,
  input  logic [DATA_W-1:0] append_data_i,
  input  logic [LEN_W-1:0]  append_len_i,
  input  logic              consume_i,
  input  logic [3:0]        consume_len_i,
  output logic [FILL_W-1:0] fill_o,
  output logic [7:0]        top_o
);

  logic [ACC_W-1:0]  acc_q, acc_d, acc_shift, append_bits;
  logic [FILL_W-1:0] fill_q, fill_d, fill_shift;
  logic [LEN_W-1:0]  len_sat;
  logic [DATA_W-1:0] mask, masked;

  // Bits below fill are kept at zero, so a consume past fill yields zero padding.
  always_comb begin
    len_sat    = (append_len_i > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : append_len_i;
    mask       = ~({DATA_W{1'b1}} >> len_sat);
    masked     = append_data_i & mask;
    acc_shift  = acc_q;
    fill_shift = fill_q;
    if (consume_i) begin
      acc_shift  = acc_q << consume_len_i;
      fill_shift = (fill_q > FILL_W'(consume_len_i)) ? fill_q - FILL_W'(consume_len_i) : '0;
    end
    append_bits = {masked, {(ACC_W-DATA_W){1'b0}}} >> fill_shift;
    acc_d       = acc_shift;
    fill_d      = fill_shift;
    if (append_i) begin
      acc_d  = acc_shift | append_bits;
      fill_d = fill_shift + FILL_W'(len_sat);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign fill_o = fill_q;
  assign top_o  = acc_q[ACC_W-1 -: 8];

endmodule

// File: rtl/jpegls_byte_packer.sv
// rtl/jpegls_byte_packer.sv - packs Golomb code words into 0xFF-stuffed bytes; JPEGLS_BYTE_COUNT_EN adds byte_count
module jpegls_byte_packer
  import jpegls_byte_packer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              flush_done
`ifdef JPEGLS_BYTE_COUNT_EN
  ,
  output logic [31:0]       byte_count
`endif
);

  localparam int FILL_W = $clog2(ACC_W + 1);

  state_e            state_q;
  logic              out_valid_q;
  logic [7:0]        out_byte_q;
  logic              last_ff_q;
  logic              flush_done_q;

  logic [FILL_W-1:0] fill;
  logic [7:0]        top;
  logic [3:0]        need;
  logic              can_load;
  logic              accept;
  logic              load_acc;
  logic              load_pad;
  logic [7:0]        load_byte;

  // in_ready is also held low while reset is asserted.
  assign in_ready  = rst_n && (state_q == ST_RUN) && (fill <= FILL_W'(ACC_W - DATA_W));
  assign accept    = in_valid && in_ready;
  assign need      = need_bits(last_ff_q);
  assign can_load  = !out_valid_q || out_ready;
  assign load_acc  = can_load &&
                     (((state_q == ST_RUN) && (fill >= FILL_W'(need))) ||
                      ((state_q == ST_FLUSH) && (fill != '0)));
  assign load_pad  = can_load && (state_q == ST_FF_PAD);
  assign load_byte = load_pad ? 8'h00 : stuff_byte(last_ff_q, top);

  jpegls_bit_accumulator #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .ACC_W  (ACC_W),
    .FILL_W (FILL_W)
  ) u_acc (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .append_i      (accept),
    .append_data_i (in_data),
    .append_len_i  (in_len),
    .consume_i     (load_acc),
    .consume_len_i (need),
    .fill_o        (fill),
    .top_o         (top)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'h00;
      last_ff_q    <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      if (load_acc || load_pad) begin
        out_valid_q <= 1'b1;
        out_byte_q  <= load_byte;
        last_ff_q   <= (load_byte == MARKER_BYTE);
      end else begin
        out_valid_q <= out_valid_q & ~out_ready;
      end
      case (state_q)
        ST_RUN: begin
          if (accept && in_flush) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // fill==0 implies no load this cycle, so last_ff_q reflects the final byte.
          if (fill == '0) state_q <= last_ff_q ? ST_FF_PAD : ST_DONE;
        end
        ST_FF_PAD: begin
          if (load_pad) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (flush_done_q) begin
            state_q   <= ST_RUN;
            last_ff_q <= 1'b0;
          end else if (!out_valid_q) begin
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_byte   = out_byte_q;
  assign flush_done = flush_done_q;

`ifdef JPEGLS_BYTE_COUNT_EN
  logic [31:0] byte_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count_q <= '0;
    end else if ((state_q == ST_DONE) && flush_done_q) begin
      byte_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      byte_count_q <= byte_count_q + 32'd1;
    end
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_jpegls_byte_packer.sv
// tb/tb_jpegls_byte_packer.sv - directed self-checking bench for jpegls_byte_packer
module tb_jpegls_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [6:0]  in_len = '0;
  logic        in_flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic        flush_done;
`ifdef JPEGLS_BYTE_COUNT_EN
  logic [31:0] byte_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit         mbits[$];
  bit         mlast_ff = 1'b0;

  always #5 clk = ~clk;

  jpegls_byte_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_len     (in_len),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .flush_done (flush_done)
`ifdef JPEGLS_BYTE_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_byte);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_emit(input logic [7:0] b);
    exp_q.push_back(b);
    mlast_ff = (b == 8'hFF);
  endtask

  task automatic model_take(input int need, output logic [7:0] b);
    bit v;
    b = 8'h00;
    for (int i = 0; i < need; i++) begin
      v = (mbits.size() > 0) ? mbits.pop_front() : 1'b0;
      b[need-1-i] = v;
    end
  endtask

  task automatic model_push(input logic [63:0] d, input int len);
    int l;
    logic [7:0] b;
    l = (len > 64) ? 64 : len;
    for (int i = 0; i < l; i++) mbits.push_back(d[63-i]);
    while (mbits.size() >= (mlast_ff ? 7 : 8)) begin
      model_take(mlast_ff ? 7 : 8, b);
      model_emit(b);
    end
  endtask

  task automatic model_flush();
    logic [7:0] b;
    if (mbits.size() > 0) begin
      model_take(mlast_ff ? 7 : 8, b);
      model_emit(b);
    end
    if (mlast_ff) model_emit(8'h00);
    mlast_ff = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input int len, input logic fl);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_len   = 7'(len);
    in_flush = fl;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_flush = 1'b0;
    check("send_accept", {63'd0, ok}, 64'd1);
    model_push(d, len);
    if (fl) model_flush();
  endtask

  task automatic wait_flush(input string tag);
    bit seen;
    int bad;
    seen = 1'b0;
    bad  = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (flush_done) seen = 1'b1;
      else begin
        if (in_ready) bad++;
        tick();
      end
    end
    check({tag, "_flush_done_seen"}, {63'd0, seen}, 64'd1);
    check({tag, "_in_ready_low_while_flushing"}, 64'(bad), 64'd0);
    check({tag, "_in_ready_low_at_pulse"}, {63'd0, in_ready}, 64'd0);
    tick();
    check({tag, "_flush_done_one_cycle"}, {63'd0, flush_done}, 64'd0);
    check({tag, "_in_ready_after_pulse"}, {63'd0, in_ready}, 64'd1);
`ifdef JPEGLS_BYTE_COUNT_EN
    check({tag, "_byte_count_cleared"}, {32'd0, byte_count}, 64'd0);
`endif
  endtask

  task automatic expect_hand(input string tag, input int n, input logic [63:0] bytes);
    for (int i = 0; i < 200 && got.size() < n; i++) tick();
    repeat (3) tick();
    check({tag, "_count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {56'd0, got[i]}, {56'd0, bytes[8*(n-1-i) +: 8]});
    got.delete();
    exp_q.delete();
  endtask

  task automatic compare_model(input string tag);
    for (int i = 0; i < 300 && got.size() < exp_q.size(); i++) tick();
    repeat (3) tick();
    check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {56'd0, got[i]}, {56'd0, exp_q[i]});
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b0;
    int bad;

    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_byte", {56'd0, out_byte}, 64'd0);
    check("rst_flush_done", {63'd0, flush_done}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
`ifdef JPEGLS_BYTE_COUNT_EN
    check("rst_byte_count", {32'd0, byte_count}, 64'd0);
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // single byte, one-cycle latency
    send(64'hA500_0000_0000_0000, 8, 1'b0);
    check("t1_no_byte_at_accept", {63'd0, out_valid}, 64'd0);
    tick();
    check("t1_out_valid", {63'd0, out_valid}, 64'd1);
    check("t1_out_byte", {56'd0, out_byte}, 64'hA5);
    tick();
    check("t1_drained", {63'd0, out_valid}, 64'd0);
    expect_hand("t1", 1, 64'hA5);

    // 0xFF followed by a stuffed 7-bit byte, then last_ff must have cleared
    send(64'hF000_0000_0000_0000, 4, 1'b0);
    send(64'hF000_0000_0000_0000, 4, 1'b0);
    send(64'hAA00_0000_0000_0000, 7, 1'b0);
    send(64'h8000_0000_0000_0000, 8, 1'b0);
    expect_hand("t2", 3, 64'hFF5580);

    // 12-bit flush with zero padding
    send(64'hABC0_0000_0000_0000, 12, 1'b1);
    check("t3_in_ready_after_accept", {63'd0, in_ready}, 64'd0);
    wait_flush("t3");
    expect_hand("t3", 2, 64'hABC0);

    // 0xFFFF flush: stuffing carries a bit into the padded tail
    send(64'hFFFF_0000_0000_0000, 16, 1'b1);
    wait_flush("t4");
    expect_hand("t4", 3, 64'hFF7F80);

    // final 0xFF forces a stuffed 0x00
    send(64'hFF00_0000_0000_0000, 8, 1'b1);
    wait_flush("t5");
    expect_hand("t5", 2, 64'hFF00);

    // oversize length saturates to 64
    send(64'h1122_3344_5566_7788, 100, 1'b1);
    wait_flush("t6");
    expect_hand("t6", 8, 64'h1122_3344_5566_7788);

    // empty flush
    send(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
    wait_flush("t7");
    expect_hand("t7", 0, 64'h0);

    // backpressure with streaming 64-bit words
    out_ready = 1'b0;
    send(64'h0123_4567_89AB_CDEF, 64, 1'b0);
    send(64'hFFFF_0011_2233_4455, 64, 1'b0);
    check("bp_in_ready_drop", {63'd0, in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    check("bp_first_byte", {56'd0, out_byte}, 64'h01);
    b0 = out_byte;
    bad = 0;
    in_data  = 64'hFEDC_BA98_7654_3210;
    in_len   = 7'd64;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_byte !== b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      tick();
    end
    check("bp_stall_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    send(64'hFEDC_BA98_7654_3210, 64, 1'b0);
    send(64'hA800_0000_0000_0000, 5, 1'b1);
    wait_flush("bp");
    compare_model("bp");

    // reset mid-word discards buffered bits
    out_ready = 1'b0;
    send(64'hABCD_E000_0000_0000, 20, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_out_byte", {56'd0, out_byte}, 64'd0);
    check("mid_rst_flush_done", {63'd0, flush_done}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
`ifdef JPEGLS_BYTE_COUNT_EN
    check("mid_rst_byte_count", {32'd0, byte_count}, 64'd0);
`endif
    mbits.delete();
    mlast_ff = 1'b0;
    got.delete();
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(64'h3C00_0000_0000_0000, 8, 1'b0);
    expect_hand("post_rst", 1, 64'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jpegls_byte_packer.md
Name: jpegls_byte_packer

Overview:
- Downstream of the limited-length Golomb encoder stage. Consumes its MSB-aligned, variable-length code words plus a valid bit count.
- Packs the words into a continuous bit stream and emits one byte per cycle over a valid/ready handshake.
- Applies JPEG-LS marker bit stuffing: after every 0xFF byte, the next byte's MSB is forced to 0.
- On request, flushes the tail with zero padding so the entropy-coded segment ends byte-aligned.

Parameters:
- DATA_W, 64, width of the input code word; code bits are MSB-aligned.
- LEN_W, 7, width of the bit-count field; legal counts are 0..DATA_W.
- ACC_W, 128, bit accumulator width; must be >= DATA_W+8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  code word present
- in_ready  out  1  packer accepts the word this cycle
- in_data  in  DATA_W  code bits, MSB-aligned; bits below in_len are don't-care
- in_len  in  LEN_W  number of valid bits in in_data (0..DATA_W)
- in_flush  in  1  qualifies the accepted word as the last of the segment
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts the byte
- out_byte  out  8  packed/stuffed byte
- flush_done  out  1  one-cycle pulse when the tail is fully emitted

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_byte=0, flush_done=0, in_ready=0.
  - Accumulator cleared, fill=0, last_ff=0, state=RUN.
  - Reset mid-word or mid-flush discards all buffered bits.
- State machine: RUN, FLUSH, FF_PAD, DONE.
- in_ready (combinational from registers): high only in RUN and when fill+DATA_W <= ACC_W.
- Accept (in_valid & in_ready):
  - The in_len MSBs of in_data are appended directly below the current fill.
  - in_len=0 is legal and appends nothing. in_len > DATA_W is saturated to DATA_W.
- Byte formation:
  - need = 7 if last_ff else 8.
  - An output load occurs when (!out_valid | out_ready) and fill >= need.
  - last_ff=0: out_byte = acc[ACC_W-1:ACC_W-8].
  - last_ff=1: out_byte = {1'b0, acc[ACC_W-1:ACC_W-7]}.
  - The accumulator shifts left by need; last_ff <= (loaded byte == 8'hFF).
  - Otherwise out_valid <= out_valid & ~out_ready.
- Simultaneous accept and load in one cycle: shift first, then append at position fill-need. Net fill = fill - need + in_len.
- Throughput: one byte per cycle sustained. Latency from accept to first byte on out_valid is 1 cycle when fill >= need after append.
- out_byte and out_valid are held stable while out_valid & !out_ready.
- Flush:
  - An accept with in_flush=1 moves RUN->FLUSH.
  - In FLUSH, in_ready=0.
  - Full bytes drain normally. When 0 < fill < need, the tail is zero-padded to need and emitted as a normal load.
  - When fill=0 and no load is pending: go to FF_PAD if last_ff, else DONE.
  - FF_PAD loads out_byte=8'h00 (stuffed zero after a final 0xFF), then goes to DONE.
  - DONE waits for the final byte to be accepted (out_valid=0). It then pulses flush_done for 1 cycle, clears last_ff, and returns to RUN.
- An in_flush with in_valid=1 but in_ready=0 has no effect until accepted.

Optional Feature:
- Macro: JPEGLS_BYTE_COUNT_EN.
- Defined: adds output byte_count[31:0].
  - Increments on each out_valid & out_ready handshake; wraps at 2^32.
  - Cleared by reset and in the cycle after the flush_done pulse.
  - Stuffed 0x00 bytes are counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: DATA_W/LEN_W/ACC_W defaults, the state encoding (RUN/FLUSH/FF_PAD/DONE), and the constant 8'hFF marker byte.
- One natural sub-module: jpegls_bit_accumulator. It holds the shift/append datapath (fill, acc, append/consume) and exposes fill and top bits. The parent keeps the FSM, stuffing and handshake.

Test Plan:
- Single 8-bit word in_data[63:56]=8'hA5, in_len=8, out_ready=1 -> one byte 8'hA5, fill returns to 0.
- Two words of 4 bits, 4'hF then 4'hF, followed by a 7-bit word 7'h55 -> bytes 8'hFF then 8'h55 (stuffed MSB 0). last_ff clears after the second byte.
- Word 12'hABC, in_len=12, in_flush=1 -> bytes 8'hAB, 8'hC0, then a flush_done pulse. in_ready=0 from the accept until the cycle after flush_done.
- 16-bit word 16'hFFFF, in_flush=1 -> emitted sequence: 8'hFF, 8'h7F, 8'h80, then flush_done.
- Backpressure: out_ready=0 for 10 cycles while 64-bit words stream in -> in_ready drops at fill+64 > 128. out_byte stays stable; no bytes lost or duplicated after release (compare against a scoreboard).
- Reset asserted mid-stream with fill=20 -> all outputs 0 immediately. After release, a new 8-bit word emits cleanly with no residual bits. With JPEGLS_BYTE_COUNT_EN, byte_count=0.
